// File: rtl/mem_bus_pkg.sv
// Shared C2 bus encodings and FSM state codes for the main-memory model.
// Imported by the main_memory top and its line store.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    C2_NOP      = 2'd0,
    C2_RESPONSE = 2'd1,
    C2_READ     = 2'd2,
    C2_WRITE    = 2'd3
  } c2_cmd_e;

  // Requester-side (C1) codes, kept here so both bus levels share one source.
  typedef enum logic [1:0] {
    C1_NOP      = 2'd0,
    C1_READ     = 2'd1,
    C1_WRITE    = 2'd2,
    C1_RESPONSE = 2'd3
  } c1_cmd_e;

  localparam int BEATS = 8;

  typedef logic [2:0] state_t;
  localparam state_t IDLE    = 3'd0;
  localparam state_t WAIT_RD = 3'd1;
  localparam state_t RESP_RD = 3'd2;
  localparam state_t CAPTURE = 3'd3;
  localparam state_t WAIT_WR = 3'd4;
  localparam state_t RESP_WR = 3'd5;

endpackage

// File: rtl/mem_line_store.sv
// Line-wide backing store. Each line is kept as the XOR against its power-up
// image, so an untouched (all-zero) entry reads back byte[a] = a[7:0] ^ a[15:8].
module mem_line_store #(
  parameter int LINE_ADDR_W = 15,
  parameter int LINE_BITS   = 128,
  parameter int OFFSET_W    = 4
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [LINE_ADDR_W-1:0] line_addr,
  input  logic [LINE_BITS-1:0]   line_in,
  output logic [LINE_BITS-1:0]   line_out
);

  localparam int LINE_BYTES = LINE_BITS / 8;

  function automatic logic [LINE_BITS-1:0] image_line(input logic [LINE_ADDR_W-1:0] line);
    logic [LINE_BITS-1:0] img;
    logic [15:0]          a;
    img = '0;
    for (int i = 0; i < LINE_BYTES; i++) begin
      a = 16'((32'(line) << OFFSET_W) | 32'(i));
      img[8*i +: 8] = a[7:0] ^ a[15:8];
    end
    return img;
  endfunction

  logic [LINE_BITS-1:0] r_delta [2**LINE_ADDR_W];
  logic [LINE_BITS-1:0] w_image;

  assign w_image = image_line(line_addr);

  // NOTE: storage arrays carry no reset; contents survive reset and only
  // the control path around them is cleared.
  always_ff @(posedge clk) begin
    if (we) r_delta[line_addr] <= line_in ^ w_image;
  end

  assign line_out = r_delta[line_addr] ^ w_image;

endmodule

// File: rtl/main_memory.sv
// Line-granular main memory on the C2 bus: 8-beat read bursts after a fixed
// latency, atomically committed 8-beat write bursts acked by one response beat.
module main_memory
  import mem_bus_pkg::*;
#(
  parameter int BUS_SIZE          = 16,
  parameter int MEM_ADDR_SIZE     = 19,
  parameter int CACHE_OFFSET_SIZE = 4,
  parameter int CACHE_LINE_SIZE   = 16,
  parameter int MEM_LATENCY       = 100
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [MEM_ADDR_SIZE-CACHE_OFFSET_SIZE-1:0] mem_address,
  inout  wire  [BUS_SIZE-1:0]                        mem_data,
  inout  wire  [1:0]                                 mem_command,
  output logic                                       busy
);

  localparam int LINE_ADDR_W = MEM_ADDR_SIZE - CACHE_OFFSET_SIZE;
  localparam int LINE_BITS   = CACHE_LINE_SIZE * 8;
  localparam int N_BEATS     = LINE_BITS / BUS_SIZE;
  localparam int BEAT_W      = $clog2(N_BEATS);
  localparam int LAT_W       = $clog2(MEM_LATENCY + 1);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N_BEATS - 1);
  // The edge that loads the counter is the first latency cycle, hence the -1.
  localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(MEM_LATENCY - 1);

  state_t                              r_state;
  logic [LAT_W-1:0]                    r_lat;
  logic [BEAT_W-1:0]                   r_beat;
  logic [LINE_ADDR_W-1:0]              r_addr;
  logic [N_BEATS-2:0][BUS_SIZE-1:0]    r_buf;

  logic                                w_we;
  logic                                w_own_cmd;
  logic                                w_own_data;
  logic [N_BEATS-1:0][BUS_SIZE-1:0]    w_line_in;
  logic [N_BEATS-1:0][BUS_SIZE-1:0]    w_line_out;

  // NOTE: every register here uses <= so all updates see pre-edge values,
  // independent of statement order inside the block.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_lat   <= '0;
      r_beat  <= '0;
      r_addr  <= '0;
      r_buf   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (mem_command == C2_READ) begin
            r_addr  <= mem_address;
            r_lat   <= LAT_LOAD;
            r_state <= WAIT_RD;
          end else if (mem_command == C2_WRITE) begin
            r_addr   <= mem_address;
            r_buf[0] <= mem_data;
            r_beat   <= BEAT_W'(1);
            r_state  <= CAPTURE;
          end
        end
        WAIT_RD: begin
          if (r_lat == '0) begin
            r_beat  <= '0;
            r_state <= RESP_RD;
          end else begin
            r_lat <= r_lat - 1'b1;
          end
        end
        RESP_RD: begin
          r_beat <= r_beat + 1'b1;
          if (r_beat == LAST_BEAT) r_state <= IDLE;
        end
        CAPTURE: begin
          r_beat <= r_beat + 1'b1;
          if (r_beat == LAST_BEAT) begin
            r_lat   <= LAT_LOAD;
            r_state <= WAIT_WR;
          end else begin
            r_buf[r_beat] <= mem_data;
          end
        end
        WAIT_WR: begin
          if (r_lat == '0) r_state <= RESP_WR;
          else             r_lat   <= r_lat - 1'b1;
        end
        RESP_WR: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // The last beat is merged straight from the bus so the line lands in one write.
  assign w_we      = (r_state == CAPTURE) && (r_beat == LAST_BEAT);
  assign w_line_in = {mem_data, r_buf};

  mem_line_store #(
    .LINE_ADDR_W (LINE_ADDR_W),
    .LINE_BITS   (LINE_BITS),
    .OFFSET_W    (CACHE_OFFSET_SIZE)
  ) u_store (
    .clk       (clk),
    .we        (w_we),
    .line_addr (r_addr),
    .line_in   (w_line_in),
    .line_out  (w_line_out)
  );

  assign w_own_cmd  = (r_state == RESP_RD) || (r_state == RESP_WR);
  assign w_own_data = (r_state == RESP_RD);

  assign mem_command = w_own_cmd  ? C2_RESPONSE        : 'z;
  assign mem_data    = w_own_data ? w_line_out[r_beat] : 'z;
  assign busy        = (r_state != IDLE);

  // Any other driver on the command bus while the memory owns it corrupts the response.
  a_bus_owned: assert property (@(posedge clk) disable iff (!reset)
    w_own_cmd |-> (mem_command == C2_RESPONSE));

endmodule
